// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the SRAM access arbiter: FSM states, grant
// owner encoding and the default bus widths.
package sram_arb_pkg;

  localparam int DEF_ADDR_W = 20;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_SETUP,
    S_W_PULSE,
    S_W_END,
    S_R_WAIT,
    S_R_DONE
  } state_t;

  typedef enum logic {
    GNT_WR,
    GNT_RD
  } grant_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_access_arbiter.sv
// Single-port SRAM controller: round-robin arbitration between a write and a
// read requester, timed active-low strobes and ownership of the DQ tri-state.
//
// Handshake: a requester raises req (with address/data) and holds it until it
// sees a one-cycle ack; address and write data are latched at the grant edge,
// and a req still high in the IDLE cycle after the ack is a new transaction.
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int WR_HOLD = 1,
  parameter int RD_WAIT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_ack,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_SRAM_ADDR,
  inout  wire  [DATA_W-1:0] io_SRAM_DQ,
  output logic              o_SRAM_WE_N,
  output logic              o_SRAM_OE_N,
  output logic              o_SRAM_CE_N,
  output logic              o_SRAM_LB_N,
  output logic              o_SRAM_UB_N
);

  localparam int CNT_W = $clog2(max2(WR_HOLD, RD_WAIT) + 1);

  state_t             state_q, state_d;
  grant_t             last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               grant_wr, grant_rd, capture;

  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rd_data_q;
  logic               we_n_q, oe_n_q, ce_n_q, dq_oe_q;
  logic               wr_ack_q, rd_ack_q, busy_q;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    capture  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Under contention the requester that did not win last time goes next.
        if (i_wr_req && (!i_rd_req || (last_q == GNT_RD))) begin
          grant_wr = 1'b1;
          state_d  = S_W_SETUP;
          last_d   = GNT_WR;
        end else if (i_rd_req) begin
          grant_rd = 1'b1;
          state_d  = S_R_WAIT;
          last_d   = GNT_RD;
          cnt_d    = CNT_W'(RD_WAIT - 1);
        end
      end
      S_W_SETUP: begin
        state_d = S_W_PULSE;
        cnt_d   = CNT_W'(WR_HOLD - 1);
      end
      S_W_PULSE: begin
        if (cnt_q == '0) state_d = S_W_END;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_W_END: state_d = S_IDLE;
      S_R_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_R_DONE;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_R_DONE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Strobes and acks are registered from the next state so pins line up with state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      last_q    <= GNT_RD;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      we_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      ce_n_q    <= 1'b1;
      dq_oe_q   <= 1'b0;
      wr_ack_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      if (grant_wr) begin
        addr_q  <= i_wr_addr;
        wdata_q <= i_wr_data;
      end
      if (grant_rd) addr_q    <= i_rd_addr;
      if (capture)  rd_data_q <= io_SRAM_DQ;
      we_n_q   <= (state_d != S_W_PULSE);
      oe_n_q   <= (state_d != S_R_WAIT);
      ce_n_q   <= (state_d == S_IDLE);
      dq_oe_q  <= (state_d == S_W_SETUP) || (state_d == S_W_PULSE) || (state_d == S_W_END);
      wr_ack_q <= (state_d == S_W_END);
      rd_ack_q <= (state_d == S_R_DONE);
      busy_q   <= (state_d != S_IDLE);
    end
  end

  assign io_SRAM_DQ  = dq_oe_q ? wdata_q : {DATA_W{1'bz}};
  assign o_SRAM_ADDR = addr_q;
  assign o_SRAM_WE_N = we_n_q;
  assign o_SRAM_OE_N = oe_n_q;
  assign o_SRAM_CE_N = ce_n_q;
  assign o_SRAM_LB_N = 1'b0;
  assign o_SRAM_UB_N = 1'b0;
  assign o_wr_ack    = wr_ack_q;
  assign o_rd_ack    = rd_ack_q;
  assign o_rd_data   = rd_data_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Bench for sram_access_arbiter: two instances (short and long strobe timing),
// each with a small SRAM model, a cycle-offset reference model and directed tests.
module tb_sram_access_arbiter;

  localparam int AW = 20;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT connections (index 0: 1/1, index 1: 3/2) ----------------
  logic          wr_req [2];
  logic          rd_req [2];
  logic [AW-1:0] wr_addr[2];
  logic [AW-1:0] rd_addr[2];
  logic [DW-1:0] wr_data[2];
  logic          wr_ack [2];
  logic          rd_ack [2];
  logic [DW-1:0] rd_data[2];
  logic          busy   [2];
  logic [AW-1:0] addr   [2];
  logic          we_n   [2];
  logic          oe_n   [2];
  logic          ce_n   [2];
  logic          lb_n   [2];
  logic          ub_n   [2];
  wire  [DW-1:0] dq_a, dq_b;

  sram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WR_HOLD(1), .RD_WAIT(1)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_req(wr_req[0]), .i_wr_addr(wr_addr[0]), .i_wr_data(wr_data[0]), .o_wr_ack(wr_ack[0]),
    .i_rd_req(rd_req[0]), .i_rd_addr(rd_addr[0]), .o_rd_data(rd_data[0]), .o_rd_ack(rd_ack[0]),
    .o_busy(busy[0]), .o_SRAM_ADDR(addr[0]), .io_SRAM_DQ(dq_a),
    .o_SRAM_WE_N(we_n[0]), .o_SRAM_OE_N(oe_n[0]), .o_SRAM_CE_N(ce_n[0]),
    .o_SRAM_LB_N(lb_n[0]), .o_SRAM_UB_N(ub_n[0])
  );

  sram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WR_HOLD(3), .RD_WAIT(2)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_req(wr_req[1]), .i_wr_addr(wr_addr[1]), .i_wr_data(wr_data[1]), .o_wr_ack(wr_ack[1]),
    .i_rd_req(rd_req[1]), .i_rd_addr(rd_addr[1]), .o_rd_data(rd_data[1]), .o_rd_ack(rd_ack[1]),
    .o_busy(busy[1]), .o_SRAM_ADDR(addr[1]), .io_SRAM_DQ(dq_b),
    .o_SRAM_WE_N(we_n[1]), .o_SRAM_OE_N(oe_n[1]), .o_SRAM_CE_N(ce_n[1]),
    .o_SRAM_LB_N(lb_n[1]), .o_SRAM_UB_N(ub_n[1])
  );

  // ---------------- SRAM pin models (16 words, low address bits) ----------------
  logic [DW-1:0] mem_a[16];
  logic [DW-1:0] mem_b[16];
  assign dq_a = !oe_n[0] ? mem_a[addr[0][3:0]] : {DW{1'bz}};
  assign dq_b = !oe_n[1] ? mem_b[addr[1][3:0]] : {DW{1'bz}};
  always @(posedge clk) begin
    if (!we_n[0]) mem_a[addr[0][3:0]] <= dq_a;
    if (!we_n[1]) mem_b[addr[1][3:0]] <= dq_b;
  end

  // ---------------- scoreboard counters ----------------
  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model: transaction timeline by cycle offset ----------------
  function automatic int wh(input int i); return (i == 0) ? 1 : 3; endfunction
  function automatic int rw(input int i); return (i == 0) ? 1 : 2; endfunction

  int            k      [2];  // 0 = idle, else cycle offset since the grant sample
  bit            kind_w [2];
  bit            last_rd[2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wdata[2];
  logic [DW-1:0] m_pend [2];
  logic [DW-1:0] m_rdata[2];
  logic [DW-1:0] mdl_mem[2][16];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        k[i] = 0; last_rd[i] = 1'b1; m_addr[i] = '0; m_rdata[i] = '0;
      end else if (k[i] == 0) begin
        if (wr_req[i] && (!rd_req[i] || last_rd[i])) begin
          kind_w[i] = 1'b1; last_rd[i] = 1'b0; k[i] = 1;
          m_addr[i] = wr_addr[i]; m_wdata[i] = wr_data[i];
          mdl_mem[i][wr_addr[i][3:0]] = wr_data[i];
        end else if (rd_req[i]) begin
          kind_w[i] = 1'b0; last_rd[i] = 1'b1; k[i] = 1;
          m_addr[i] = rd_addr[i];
          m_pend[i] = mdl_mem[i][rd_addr[i][3:0]];
        end
      end else begin
        if (k[i] == (kind_w[i] ? wh(i) + 2 : rw(i) + 1)) k[i] = 0;
        else k[i] = k[i] + 1;
        if (!kind_w[i] && k[i] == rw(i) + 1) m_rdata[i] = m_pend[i];
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [43:0] exp_v, act_v;
  logic [DW-1:0] dq_v;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        exp_v = {k[i] != 0, k[i] == 0,
                 !(kind_w[i] && k[i] >= 2 && k[i] <= wh(i) + 1),
                 !(!kind_w[i] && k[i] >= 1 && k[i] <= rw(i)),
                 kind_w[i] && k[i] == wh(i) + 2,
                 !kind_w[i] && k[i] == rw(i) + 1,
                 1'b0, 1'b0, m_addr[i], m_rdata[i]};
        act_v = {busy[i], ce_n[i], we_n[i], oe_n[i], wr_ack[i], rd_ack[i],
                 lb_n[i], ub_n[i], addr[i], rd_data[i]};
        check($sformatf("outputs inst%0d", i), 64'(act_v), 64'(exp_v));
        check($sformatf("we_oe_overlap inst%0d", i), 64'(!we_n[i] && !oe_n[i]), 64'd0);
        if (kind_w[i] && k[i] != 0) begin
          dq_v = (i == 0) ? dq_a : dq_b;
          check($sformatf("dq_drive inst%0d", i), 64'(dq_v), 64'(m_wdata[i]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_txn(input int i, input bit is_wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit scramble,
                         input int exp_lat, input int exp_low, input string nm);
    int t0, low, lat;
    bit got;
    @(negedge clk);
    if (is_wr) begin wr_addr[i] = a; wr_data[i] = d; wr_req[i] = 1'b1; end
    else       begin rd_addr[i] = a; rd_req[i] = 1'b1; end
    t0 = cyc; low = 0; lat = 999; got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (scramble && cyc - t0 == 1) begin
        wr_addr[i] = a ^ 20'h0000F; wr_data[i] = ~d; rd_addr[i] = a ^ 20'h0000C;
      end
      if (is_wr ? !we_n[i] : !oe_n[i]) low++;
      if (is_wr ? wr_ack[i] : rd_ack[i]) begin
        got = 1'b1; lat = cyc - t0;
        if (is_wr) wr_req[i] = 1'b0; else rd_req[i] = 1'b0;
      end
    end
    if (!got) begin wr_req[i] = 1'b0; rd_req[i] = 1'b0; end
    check({nm, " latency"}, 64'(lat), 64'(exp_lat));
    check({nm, " strobe_cycles"}, 64'(low), 64'(exp_low));
  endtask

  logic [0:0] exp_q[$];
  int         wack_t[$];

  initial begin
    int t0, n_ack, rd_cnt;
    bit got_w, got_r;
    for (int j = 0; j < 16; j++) begin
      mem_a[j] = 16'(j * 16'h0111); mem_b[j] = 16'(j * 16'h0111);
      mdl_mem[0][j] = 16'(j * 16'h0111); mdl_mem[1][j] = 16'(j * 16'h0111);
    end
    mem_a[15] = 16'h1234; mdl_mem[0][15] = 16'h1234;
    for (int i = 0; i < 2; i++) begin
      wr_req[i] = 0; rd_req[i] = 0; wr_addr[i] = '0; rd_addr[i] = '0; wr_data[i] = '0;
    end

    // Reset with both requests pending: first grant must go to the writer.
    rst_n = 1'b0;
    wr_req[0] = 1'b1; rd_req[0] = 1'b1;
    wr_addr[0] = 20'h00012; wr_data[0] = 16'hBEEF; rd_addr[0] = 20'hFFFFF;
    @(posedge clk); chk_en = 1'b1;
    @(negedge clk);
    check("rst we_n", 64'(we_n[0]), 64'd1);
    check("rst oe_n", 64'(oe_n[0]), 64'd1);
    check("rst ce_n", 64'(ce_n[0]), 64'd1);
    check("rst acks", 64'({wr_ack[0], rd_ack[0]}), 64'd0);
    check("rst addr", 64'(addr[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; t0 = cyc; got_w = 0; got_r = 0;
    for (int n = 0; n < 30 && !got_r; n++) begin
      @(negedge clk);
      if (cyc - t0 == 4) check("busy low after write", 64'(busy[0]), 64'd0);
      if (wr_ack[0] && !got_w) begin
        got_w = 1; wr_req[0] = 1'b0;
        check("first write ack cycle", 64'(cyc - t0), 64'd3);
      end
      if (rd_ack[0]) begin
        got_r = 1; rd_req[0] = 1'b0;
        check("write granted before read", 64'(got_w), 64'd1);
        check("read ack cycle", 64'(cyc - t0), 64'd6);
        check("read data 0xFFFFF", 64'(rd_data[0]), 64'h1234);
      end
    end
    check("reset-release read served", 64'(got_r), 64'd1);
    repeat (3) @(negedge clk);
    check("read data held", 64'(rd_data[0]), 64'h1234);

    // Single write then read-back on the short-timing instance.
    run_txn(0, 1'b1, 20'h00003, 16'h5A5A, 1'b0, 3, 1, "wr a");
    run_txn(0, 1'b0, 20'h00003, 16'h0000, 1'b0, 2, 1, "rd a");
    check("readback a", 64'(rd_data[0]), 64'h5A5A);

    // Continuous contention: grants must alternate starting with the writer.
    @(negedge clk);
    wr_addr[0] = 20'h00004; wr_data[0] = 16'h1111; rd_addr[0] = 20'h00004;
    wr_req[0] = 1'b1; rd_req[0] = 1'b1; t0 = cyc; n_ack = 0;
    for (int j = 0; j < 8; j++) exp_q.push_back(1'((j % 2) == 0));
    for (int n = 0; n < 100 && n_ack < 8; n++) begin
      @(negedge clk);
      if (wr_ack[0] || rd_ack[0]) begin
        check("grant order", 64'(wr_ack[0]), 64'(exp_q.pop_front()));
        if (wr_ack[0]) wack_t.push_back(cyc - t0);
        n_ack++;
        if (n_ack == 8) begin wr_req[0] = 1'b0; rd_req[0] = 1'b0; end
      end
    end
    wr_req[0] = 1'b0; rd_req[0] = 1'b0;
    check("contention acks", 64'(n_ack), 64'd8);
    if (wack_t.size() >= 2) begin
      check("contention wack0", 64'(wack_t[0]), 64'd3);
      check("contention wack1", 64'(wack_t[1]), 64'd10);
    end else begin
      check("contention write acks seen", 64'(wack_t.size()), 64'd4);
    end

    // Reset during the write pulse aborts; the held request restarts from setup.
    @(negedge clk);
    wr_addr[0] = 20'h00006; wr_data[0] = 16'h7777; wr_req[0] = 1'b1; got_w = 0;
    for (int n = 0; n < 10 && !got_w; n++) begin
      @(negedge clk);
      if (!we_n[0]) got_w = 1;
    end
    check("pulse reached", 64'(got_w), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort we_n", 64'(we_n[0]), 64'd1);
    check("abort no ack", 64'(wr_ack[0]), 64'd0);
    check("abort busy", 64'(busy[0]), 64'd0);
    rst_n = 1'b1; t0 = cyc; got_w = 0;
    for (int n = 0; n < 20 && !got_w; n++) begin
      @(negedge clk);
      if (wr_ack[0]) begin
        got_w = 1; wr_req[0] = 1'b0;
        check("restart ack cycle", 64'(cyc - t0), 64'd3);
      end
    end
    check("restart served", 64'(got_w), 64'd1);

    // Long-timing instance with inputs changing mid-transaction.
    run_txn(1, 1'b1, 20'h00005, 16'hA5A5, 1'b1, 5, 3, "wr b");
    run_txn(1, 1'b0, 20'h00005, 16'h0000, 1'b1, 3, 2, "rd b");
    check("readback b", 64'(rd_data[1]), 64'hA5A5);

    // A read request dropped before it could be granted is never served.
    @(negedge clk);
    wr_addr[1] = 20'h00008; wr_data[1] = 16'h0F0F; wr_req[1] = 1'b1; rd_addr[1] = 20'h00008;
    @(negedge clk); rd_req[1] = 1'b1;
    @(negedge clk); rd_req[1] = 1'b0;
    rd_cnt = 0; got_w = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (wr_ack[1]) begin got_w = 1; wr_req[1] = 1'b0; end
      if (rd_ack[1]) rd_cnt++;
    end
    check("dropped write served", 64'(got_w), 64'd1);
    check("dropped read not served", 64'(rd_cnt), 64'd0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
